// File: rtl/pipe_axi_arbiter.sv
// pipe_axi_arbiter
//
// Purpose: shares the core's single AXI-Lite master port between the
// instruction fetch unit (read only) and the load/store unit (read and
// write). One transaction is in flight at a time. Requesters are granted
// round-robin, and a grant is held from the address handshake through the
// response handshake. Address, data and response payloads pass through
// combinationally from whichever requester holds the grant.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   ifu_ar*/ifu_r*      IFU read address / read data channels (slave side)
//   lsu_ar*/lsu_r*      LSU read address / read data channels (slave side)
//   lsu_aw*/lsu_w*      LSU write address / write data channels (slave side)
//   lsu_b*              LSU write response channel (slave side)
//   m_*                 AXI-Lite master port toward the crossbar
module pipe_axi_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // IFU read port
  input  logic [ADDR_WIDTH-1:0]   ifu_araddr_i,
  input  logic                    ifu_arvalid_i,
  output logic                    ifu_arready_o,
  output logic                    ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
  input  logic                    ifu_rready_i,
  // LSU read port
  input  logic [ADDR_WIDTH-1:0]   lsu_araddr_i,
  input  logic                    lsu_arvalid_i,
  output logic                    lsu_arready_o,
  output logic                    lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic [1:0]              lsu_rresp_o,
  input  logic                    lsu_rready_i,
  // LSU write port
  input  logic [ADDR_WIDTH-1:0]   lsu_awaddr_i,
  input  logic                    lsu_awvalid_i,
  output logic                    lsu_awready_o,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_wstrb_i,
  input  logic                    lsu_wvalid_i,
  output logic                    lsu_wready_o,
  output logic                    lsu_bvalid_o,
  output logic [1:0]              lsu_bresp_o,
  input  logic                    lsu_bready_i,
  // AXI-Lite master port
  output logic [ADDR_WIDTH-1:0]   m_araddr_o,
  output logic                    m_arvalid_o,
  input  logic                    m_arready_i,
  input  logic                    m_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic [1:0]              m_rresp_i,
  output logic                    m_rready_o,
  output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
  output logic                    m_awvalid_o,
  input  logic                    m_awready_i,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
  output logic                    m_wvalid_o,
  input  logic                    m_wready_i,
  input  logic                    m_bvalid_i,
  input  logic [1:0]              m_bresp_i,
  output logic                    m_bready_o
);

  typedef enum logic [2:0] {
    IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_W, LSU_B
  } state_e;

  state_e state_q, state_d;
  logic   lastGrantLsu_q, lastGrantLsu_d;
  logic   awDone_q, awDone_d;
  logic   wDone_q, wDone_d;

  logic ifuReq, lsuReq, grantIfu;
  logic awHs, wHs;

  assign ifuReq = ifu_arvalid_i;
  assign lsuReq = lsu_awvalid_i | lsu_arvalid_i;

  // On a tie the IFU wins only if the LSU held the previous grant.
  assign grantIfu = ifuReq & (~lsuReq | lastGrantLsu_q);

  // Once a write channel has handshaken its valid is masked, so a
  // requester that keeps valid high cannot produce a second beat.
  assign awHs = (state_q == LSU_W) & lsu_awvalid_i & ~awDone_q & m_awready_i;
  assign wHs  = (state_q == LSU_W) & lsu_wvalid_i & ~wDone_q & m_wready_i;

  // Next-state logic: arbitration in IDLE, then walk the granted
  // transaction through its address and response phases.
  always_comb begin
    state_d        = state_q;
    lastGrantLsu_d = lastGrantLsu_q;
    awDone_d       = awDone_q;
    wDone_d        = wDone_q;
    case (state_q)
      IDLE: begin
        if (grantIfu) begin
          state_d        = IFU_AR;
          lastGrantLsu_d = 1'b0;
        end else if (lsuReq) begin
          state_d        = lsu_awvalid_i ? LSU_W : LSU_AR;
          lastGrantLsu_d = 1'b1;
        end
      end
      IFU_AR: if (ifu_arvalid_i & m_arready_i) state_d = IFU_R;
      IFU_R:  if (m_rvalid_i & ifu_rready_i)   state_d = IDLE;
      LSU_AR: if (lsu_arvalid_i & m_arready_i) state_d = LSU_R;
      LSU_R:  if (m_rvalid_i & lsu_rready_i)   state_d = IDLE;
      LSU_W: begin
        if ((awDone_q | awHs) & (wDone_q | wHs)) begin
          state_d  = LSU_B;
          awDone_d = 1'b0;
          wDone_d  = 1'b0;
        end else begin
          awDone_d = awDone_q | awHs;
          wDone_d  = wDone_q | wHs;
        end
      end
      LSU_B:  if (m_bvalid_i & lsu_bready_i)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; an asynchronous reset abandons any transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      lastGrantLsu_q <= 1'b1;
      awDone_q       <= 1'b0;
      wDone_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      lastGrantLsu_q <= lastGrantLsu_d;
      awDone_q       <= awDone_d;
      wDone_q        <= wDone_d;
    end
  end

  // Output routing: everything defaults to 0 and only the channels of the
  // current phase are connected between the granted requester and the bus.
  always_comb begin
    ifu_arready_o = 1'b0;
    ifu_rvalid_o  = 1'b0;
    ifu_rdata_o   = '0;
    lsu_arready_o = 1'b0;
    lsu_rvalid_o  = 1'b0;
    lsu_rdata_o   = '0;
    lsu_rresp_o   = '0;
    lsu_awready_o = 1'b0;
    lsu_wready_o  = 1'b0;
    lsu_bvalid_o  = 1'b0;
    lsu_bresp_o   = '0;
    m_araddr_o    = '0;
    m_arvalid_o   = 1'b0;
    m_rready_o    = 1'b0;
    m_awaddr_o    = '0;
    m_awvalid_o   = 1'b0;
    m_wdata_o     = '0;
    m_wstrb_o     = '0;
    m_wvalid_o    = 1'b0;
    m_bready_o    = 1'b0;
    case (state_q)
      IFU_AR: begin
        m_araddr_o    = ifu_araddr_i;
        m_arvalid_o   = ifu_arvalid_i;
        ifu_arready_o = m_arready_i;
      end
      IFU_R: begin
        ifu_rvalid_o = m_rvalid_i;
        ifu_rdata_o  = m_rdata_i;
        m_rready_o   = ifu_rready_i;
      end
      LSU_AR: begin
        m_araddr_o    = lsu_araddr_i;
        m_arvalid_o   = lsu_arvalid_i;
        lsu_arready_o = m_arready_i;
      end
      LSU_R: begin
        lsu_rvalid_o = m_rvalid_i;
        lsu_rdata_o  = m_rdata_i;
        lsu_rresp_o  = m_rresp_i;
        m_rready_o   = lsu_rready_i;
      end
      LSU_W: begin
        m_awaddr_o    = lsu_awaddr_i;
        m_awvalid_o   = lsu_awvalid_i & ~awDone_q;
        lsu_awready_o = m_awready_i & ~awDone_q;
        m_wdata_o     = lsu_wdata_i;
        m_wstrb_o     = lsu_wstrb_i;
        m_wvalid_o    = lsu_wvalid_i & ~wDone_q;
        lsu_wready_o  = m_wready_i & ~wDone_q;
      end
      LSU_B: begin
        lsu_bvalid_o = m_bvalid_i;
        lsu_bresp_o  = m_bresp_i;
        m_bready_o   = lsu_bready_i;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/pipe_axi_arbiter.md
# pipe_axi_arbiter

Shares the core's single AXI-Lite master port between the instruction fetch unit (read-only) and the load/store unit (read and write). It sits between the pipeline's IFU/LSU bus ports and the memory/peripheral crossbar. One transaction is in flight at a time, and requesters are granted round-robin. Each grant is held from address handshake through response handshake.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all AR/AW channels
- DATA_WIDTH, 32, data width of R/W channels; wstrb is DATA_WIDTH/8

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- ifu_araddr_i  in  ADDR_WIDTH  IFU read address
- ifu_arvalid_i  in  1  IFU read request
- ifu_arready_o  out  1  IFU AR accepted
- ifu_rvalid_o  out  1  IFU read data valid
- ifu_rdata_o  out  DATA_WIDTH  IFU read data
- ifu_rready_i  in  1  IFU ready for data
- lsu_araddr_i / lsu_arvalid_i / lsu_arready_o  in/in/out  ADDR_WIDTH/1/1  LSU read address channel
- lsu_rvalid_o / lsu_rdata_o / lsu_rresp_o / lsu_rready_i  out/out/out/in  1/DATA_WIDTH/2/1  LSU read data channel
- lsu_awaddr_i / lsu_awvalid_i / lsu_awready_o  in/in/out  ADDR_WIDTH/1/1  LSU write address channel
- lsu_wdata_i / lsu_wstrb_i / lsu_wvalid_i / lsu_wready_o  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  LSU write data channel
- lsu_bvalid_o / lsu_bresp_o / lsu_bready_i  out/out/in  1/2/1  LSU write response channel
- m_* (araddr, arvalid, arready, rvalid, rdata, rresp, rready, awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bvalid, bresp, bready)  AXI-Lite master, directions mirrored, same widths

## Operation
- FSM states: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_W, LSU_B.
- IDLE arbitration. IFU request = ifu_arvalid_i. LSU request = lsu_awvalid_i | lsu_arvalid_i. LSU write takes precedence over LSU read when both are high.
  - Only one requester active: grant it.
  - Both active: grant the one not in last_grant. last_grant updates on every grant.
- IFU_AR: m_ar* driven from IFU; ifu_arready_o = m_arready. Handshake -> IFU_R.
- IFU_R: ifu_rvalid_o = m_rvalid, ifu_rdata_o = m_rdata, m_rready = ifu_rready_i. Handshake -> IDLE.
- LSU_AR / LSU_R: same as the IFU states, routed to the LSU; m_rresp passes to lsu_rresp_o.
- LSU_W: m_awvalid and m_wvalid are driven independently. Flags aw_done and w_done record each handshake, so the two may complete in either order or the same cycle. The LSU must hold AW and W stable until accepted. Both done -> LSU_B and flags clear.
- LSU_B: lsu_bvalid_o = m_bvalid, m_bready = lsu_bready_i. Handshake -> IDLE.
- Non-granted requester sees arready/awready/wready = 0 and rvalid/bvalid = 0. Its data outputs are don't-care and are driven 0.
- All m_* valid/ready outputs are 0 in IDLE.
- Address and data are passed combinationally from the granted requester. No payload registering.

## Timing
- Reset values: state IDLE, last_grant = LSU (IFU wins the first tie), aw_done = w_done = 0. All valid/ready outputs 0, all data outputs 0.
- Arbitration latency is 1 cycle: a request seen in IDLE at edge N gives m_arvalid/m_awvalid high in cycle N+1.
- Minimum read is 3 cycles: IDLE, AR, R with same-cycle ready.
- Minimum write is 3 cycles: IDLE, W with AW and W accepted together, B.
- Back-to-back: after a response handshake the FSM is in IDLE for exactly one cycle before the next grant.
- Grant is never revoked mid-transaction, even if the requester drops valid after its address handshake.
- A requester deasserting valid in IDLE before a grant is simply not granted. A request dropped during its AR/W state is a protocol violation; behaviour is undefined.
- Async reset mid-transaction: all outputs drop immediately and the FSM returns to IDLE. The outstanding bus response is discarded.

## Test plan
- Single IFU read, araddr=0x80000000, slave returns 0x00000413 after 2 cycles -> ifu_rvalid_o with rdata 0x00000413; LSU outputs stay 0.
- IFU and LSU read assert together from reset -> IFU granted first. On the next tie, LSU is granted. Grant order alternates IFU, LSU, IFU.
- LSU write 0x80001000 / 0xdeadbeef / wstrb 0xF, slave accepts W two cycles before AW -> exactly one m_wvalid and one m_awvalid handshake, then lsu_bvalid_o with bresp 0.
- LSU asserts awvalid and arvalid simultaneously -> write performed first, then read after one IDLE cycle.
- IFU rready held low 5 cycles during IFU_R -> m_rready low, FSM stays in IFU_R, LSU request is stalled until the IFU handshake.
- rst_i asserted in LSU_B with bvalid pending -> next cycle state IDLE, lsu_bvalid_o = 0, and the first post-reset tie is granted to the IFU.
